// File: rtl/icache_refill_ctrl_if.sv
// Core-fetch and memory-refill signal bundle for the instruction cache refill
// controller. The slave side is the controller; the master side is the
// core/memory environment driving it.
interface icache_refill_ctrl_if #(
  parameter int BITSIZE = 32
);
  logic               req_i;
  logic [BITSIZE-1:0] addr_i;
  logic               flush_i;
  logic               ready_o;
  logic               rvalid_o;
  logic [BITSIZE-1:0] rdata_o;
  logic               mem_req_o;
  logic [BITSIZE-1:0] mem_addr_o;
  logic               mem_valid_i;
  logic [BITSIZE-1:0] mem_data_i;

  modport slave (
    input  req_i, addr_i, flush_i, mem_valid_i, mem_data_i,
    output ready_o, rvalid_o, rdata_o, mem_req_o, mem_addr_o
  );

  modport master (
    output req_i, addr_i, flush_i, mem_valid_i, mem_data_i,
    input  ready_o, rvalid_o, rdata_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache with a word-serial line refill.
// Hits answer one cycle after acceptance; misses refill the whole line from
// memory and then answer from the array (no bypass of the returning word).
module icache_refill_ctrl #(
  parameter int BITSIZE    = 32,
  parameter int LINE_WORDS = 4,
  parameter int N_LINES    = 4
) (
  input  logic               clk,
  input  logic               resetn_i,
  icache_refill_ctrl_if.slave bus
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(N_LINES);
  localparam int TW = BITSIZE - 2 - OB - IB;

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_e;

  state_e                                      state_q, state_d;
  logic [N_LINES-1:0]                          valid_q;
  logic [N_LINES-1:0][TW-1:0]                  tag_q;
  logic [N_LINES-1:0][LINE_WORDS-1:0][BITSIZE-1:0] data_q;
  logic [OB-1:0]                               cnt_q;
  logic [TW-1:0]                               cap_tag_q;
  logic [IB-1:0]                               cap_idx_q;
  logic [OB-1:0]                               cap_off_q;
  logic                                        rvalid_q;
  logic [BITSIZE-1:0]                          rdata_q;

  logic [OB-1:0] in_off;
  logic [IB-1:0] in_idx;
  logic [TW-1:0] in_tag;
  logic          hit, accept, last_word;
  logic          unused_addr_lsb;

  assign in_off          = bus.addr_i[OB+1:2];
  assign in_idx          = bus.addr_i[OB+IB+1:OB+2];
  assign in_tag          = bus.addr_i[BITSIZE-1:OB+IB+2];
  assign unused_addr_lsb = ^bus.addr_i[1:0];

  assign hit       = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign accept    = (state_q == IDLE) && !bus.flush_i && bus.req_i;
  assign last_word = &cnt_q;

  // ready is gated by reset so it reads 0 while resetn_i is held low
  assign bus.ready_o    = resetn_i && (state_q == IDLE) && !bus.flush_i;
  assign bus.mem_req_o  = (state_q == REFILL);
  assign bus.mem_addr_o = (state_q == REFILL) ? {cap_tag_q, cap_idx_q, cnt_q, 2'b00}
                                              : '0;
  assign bus.rvalid_o   = rvalid_q;
  assign bus.rdata_o    = rdata_q;

  // Next-state: miss starts a refill, last beat moves to the response cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !hit) state_d = REFILL;
      REFILL:  if (bus.mem_valid_i && last_word) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, beat counter, valid bits, captured request, response
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= '0;
      cap_tag_q <= '0;
      cap_idx_q <= '0;
      cap_off_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.flush_i) begin
            valid_q <= '0;
          end else if (bus.req_i) begin
            cap_tag_q <= in_tag;
            cap_idx_q <= in_idx;
            cap_off_q <= in_off;
            if (hit) begin
              rvalid_q <= 1'b1;
              rdata_q  <= data_q[in_idx][in_off];
            end else begin
              // the line is overwritten piecewise; never let a partial line hit
              valid_q[in_idx] <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (bus.mem_valid_i) begin
            cnt_q <= cnt_q + 1'b1;  // wraps to 0 after the last beat
            if (last_word) valid_q[cap_idx_q] <= 1'b1;
          end
        end
        RESPOND: begin
          rvalid_q <= 1'b1;
          rdata_q  <= data_q[cap_idx_q][cap_off_q];
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays: written only by refill beats, no reset needed
  always_ff @(posedge clk) begin
    if (state_q == REFILL && bus.mem_valid_i) begin
      data_q[cap_idx_q][cnt_q] <= bus.mem_data_i;
      if (last_word) tag_q[cap_idx_q] <= cap_tag_q;
    end
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed + randomized bench for icache_refill_ctrl against an array-based
// cache model (valid/tag/data per line, addresses split arithmetically).
module tb_icache_refill_ctrl;
  localparam int BITSIZE = 32;
  localparam int LW = 4;
  localparam int NL = 4;
  localparam int OB = $clog2(LW);
  localparam int IB = $clog2(NL);

  logic clk = 1'b0;
  logic resetn_i = 1'b0;
  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.BITSIZE(BITSIZE)) bus ();

  icache_refill_ctrl #(.BITSIZE(BITSIZE), .LINE_WORDS(LW), .N_LINES(NL)) dut (
    .clk(clk), .resetn_i(resetn_i), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  bit          m_valid [NL];
  logic [31:0] m_tag   [NL];
  logic [31:0] m_data  [NL][LW];

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  // One core fetch: accept, then either a hit response or a full refill
  task automatic fetch(input logic [31:0] a, input int mingap, input int maxgap,
                       input bit noise);
    int idx, off, g;
    logic [31:0] tg, base, d;
    bit hit;
    idx  = int'((a >> 2 >> OB) % NL);
    off  = int'((a >> 2) % LW);
    tg   = a >> (2 + OB + IB);
    base = (a >> 2 >> OB) * (LW * 4);
    @(negedge clk);
    bus.req_i = 1'b1; bus.addr_i = a; bus.flush_i = 1'b0;
    bus.mem_valid_i = noise ? 1'($urandom) : 1'b0;  // ignored in IDLE
    bus.mem_data_i = $urandom;
    #1 chk("ready_idle", 32'(bus.ready_o), 32'd1);
    hit = m_valid[idx] && m_tag[idx] == tg;
    @(negedge clk);
    bus.req_i = 1'b0; bus.addr_i = $urandom; bus.mem_valid_i = 1'b0;
    #1;
    if (hit) begin
      chk("hit_rvalid", 32'(bus.rvalid_o), 32'd1);
      chk("hit_rdata", bus.rdata_o, m_data[idx][off]);
      chk("hit_memreq", 32'(bus.mem_req_o), 32'd0);
    end else begin
      m_valid[idx] = 1'b0;
      chk("miss_rvalid", 32'(bus.rvalid_o), 32'd0);
      for (int k = 0; k < LW; k++) begin
        g = $urandom_range(maxgap, mingap);
        repeat (g) begin
          if (noise) begin
            bus.req_i = 1'($urandom); bus.flush_i = 1'($urandom); bus.addr_i = $urandom;
          end
          #1;
          chk("gap_memreq", 32'(bus.mem_req_o), 32'd1);
          chk("gap_memaddr", bus.mem_addr_o, base + 32'(4 * k));
          chk("gap_ready", 32'(bus.ready_o), 32'd0);
          @(negedge clk);
        end
        d = $urandom;
        bus.mem_valid_i = 1'b1; bus.mem_data_i = d;
        #1;
        chk("beat_memreq", 32'(bus.mem_req_o), 32'd1);
        chk("beat_memaddr", bus.mem_addr_o, base + 32'(4 * k));
        m_data[idx][k] = d;
        @(negedge clk);
        bus.mem_valid_i = 1'b0; bus.mem_data_i = $urandom;
      end
      bus.req_i = 1'b0; bus.flush_i = 1'b0;
      m_tag[idx] = tg; m_valid[idx] = 1'b1;
      #1;
      chk("respond_memreq", 32'(bus.mem_req_o), 32'd0);
      chk("respond_rvalid_early", 32'(bus.rvalid_o), 32'd0);
      chk("respond_ready", 32'(bus.ready_o), 32'd0);
      @(negedge clk);
      #1;
      chk("refill_rvalid", 32'(bus.rvalid_o), 32'd1);
      chk("refill_rdata", bus.rdata_o, m_data[idx][off]);
      chk("refill_ready_back", 32'(bus.ready_o), 32'd1);
    end
  endtask

  // Flush in IDLE with a competing request that must be dropped
  task automatic flush_with_req(input logic [31:0] a);
    @(negedge clk);
    bus.flush_i = 1'b1; bus.req_i = 1'b1; bus.addr_i = a;
    #1 chk("flush_ready", 32'(bus.ready_o), 32'd0);
    model_clear();
    @(negedge clk);
    bus.flush_i = 1'b0; bus.req_i = 1'b0;
    #1;
    chk("flush_rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("flush_memreq", 32'(bus.mem_req_o), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    bus.req_i = 1'b1; bus.addr_i = 32'h40; bus.flush_i = 1'b0;
    bus.mem_valid_i = 1'b0; bus.mem_data_i = '0;
    model_clear();

    // reset values while resetn_i is low
    #2;
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    chk("rst_memreq", 32'(bus.mem_req_o), 32'd0);
    chk("rst_memaddr", bus.mem_addr_o, 32'd0);
    @(negedge clk); @(negedge clk);
    bus.req_i = 1'b0;
    resetn_i = 1'b1;

    // cold miss, hit, back-to-back hits
    fetch(32'h40, 0, 0, 1'b0);
    fetch(32'h48, 0, 0, 1'b0);
    @(negedge clk);
    bus.req_i = 1'b1; bus.addr_i = 32'h40;
    @(negedge clk);
    bus.addr_i = 32'h4C;
    #1;
    chk("b2b_rvalid0", 32'(bus.rvalid_o), 32'd1);
    chk("b2b_rdata0", bus.rdata_o, m_data[0][0]);
    @(negedge clk);
    bus.req_i = 1'b0;
    #1;
    chk("b2b_rvalid1", 32'(bus.rvalid_o), 32'd1);
    chk("b2b_rdata1", bus.rdata_o, m_data[0][3]);

    // conflict on index 0, then the evicted line misses again
    fetch(32'h80, 0, 0, 1'b0);
    fetch(32'h40, 0, 0, 1'b0);

    // flush drops the request, next access misses
    flush_with_req(32'h48);
    fetch(32'h48, 0, 0, 1'b0);

    // gapped refill with 3 idle cycles before every beat
    fetch(32'h1D4, 3, 3, 1'b1);

    // reset after two beats of a refill
    @(negedge clk);
    bus.req_i = 1'b1; bus.addr_i = 32'hC0;
    @(negedge clk);
    bus.req_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.mem_valid_i = 1'b1; bus.mem_data_i = $urandom;
      @(negedge clk);
    end
    bus.mem_valid_i = 1'b0;
    resetn_i = 1'b0;
    #1;
    chk("midrst_memreq", 32'(bus.mem_req_o), 32'd0);
    chk("midrst_memaddr", bus.mem_addr_o, 32'd0);
    chk("midrst_ready", 32'(bus.ready_o), 32'd0);
    chk("midrst_rvalid", 32'(bus.rvalid_o), 32'd0);
    model_clear();
    @(negedge clk);
    resetn_i = 1'b1;
    fetch(32'h40, 0, 0, 1'b0);
    fetch(32'hC0, 0, 1, 1'b0);

    // randomized traffic over a small tag space so hits and conflicts mix
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(7, 0) == 0) begin
        flush_with_req($urandom);
      end else begin
        a = ($urandom_range(3, 0) << (2 + OB + IB)) | ($urandom_range(NL * LW * 4 - 1, 0));
        fetch(a, 0, $urandom_range(3, 0), 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter BITSIZE, default 32, data and address width in bits.
REQ-002 SHALL have parameter LINE_WORDS, default 4, words per line (power of two, >=2).
REQ-003 SHALL have parameter N_LINES, default 4, number of direct-mapped lines (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port resetn_i, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port req_i, input, 1, core fetch request.
REQ-007 SHALL have port addr_i, input, BITSIZE, byte fetch address; bits [1:0] ignored.
REQ-008 SHALL have port flush_i, input, 1, invalidate all lines.
REQ-009 SHALL have port ready_o, output, 1, controller accepts req_i this cycle.
REQ-010 SHALL have port rvalid_o, output, 1, rdata_o valid, one-cycle pulse.
REQ-011 SHALL have port rdata_o, output, BITSIZE, fetched word.
REQ-012 SHALL have port mem_req_o, output, 1, refill request to memory.
REQ-013 SHALL have port mem_addr_o, output, BITSIZE, word-aligned refill byte address.
REQ-014 SHALL have port mem_valid_i, input, 1, memory returns one word.
REQ-015 SHALL have port mem_data_i, input, BITSIZE, returned word.

Function
REQ-016 SHALL decode addr_i as: offset = [OB+1:2], OB = log2(LINE_WORDS); index = next log2(N_LINES) bits; tag = remaining upper bits.
REQ-017 SHALL hold per line a valid bit, a tag and LINE_WORDS data words.
REQ-018 SHALL implement FSM states IDLE, REFILL, RESPOND; reset state IDLE.
REQ-019 SHALL drive ready_o = 1 only in IDLE with flush_i = 0.
REQ-020 SHALL accept a request in IDLE when req_i & ready_o; addr_i is captured in that cycle.
REQ-021 SHALL, on hit (valid and tag match), pulse rvalid_o with the addressed word in the next cycle and stay in IDLE (1-cycle latency, back-to-back hits allowed).
REQ-022 SHALL, on miss, go to REFILL next cycle and assert mem_req_o with mem_addr_o = line base (offset bits and [1:0] zero).
REQ-023 SHALL, in REFILL, hold mem_req_o high; on each mem_valid_i write mem_data_i into word[count] and increment count, with mem_addr_o = line base + 4*count.
REQ-024 SHALL ignore mem_valid_i outside REFILL; gaps in mem_valid_i stall the refill indefinitely.
REQ-025 SHALL, on the mem_valid_i delivering word LINE_WORDS-1, set the line's tag and valid bit, deassert mem_req_o next cycle, and go to RESPOND; count wraps to 0.
REQ-026 SHALL, in RESPOND, pulse rvalid_o with the originally requested word and return to IDLE (no memory-to-core bypass).
REQ-027 SHALL clear the line valid bit when REFILL is entered, so a partial line never hits.
REQ-028 SHALL, on flush_i in IDLE, clear all valid bits in that cycle; a simultaneous req_i is not accepted.
REQ-029 SHALL ignore flush_i in REFILL and RESPOND.
REQ-030 SHALL keep rvalid_o low except the pulses defined above; rdata_o is don't-care when rvalid_o = 0.
REQ-031 SHALL NOT accept req_i in REFILL or RESPOND; req_i there has no effect.

Reset
REQ-032 SHALL, while resetn_i = 0, force state IDLE, count 0, all valid bits 0, mem_req_o 0, rvalid_o 0, rdata_o 0, mem_addr_o 0, ready_o 0.
REQ-033 SHALL, on reset mid-REFILL, discard the partial line; after release the line misses.
REQ-034 SHALL not require tag/data arrays to be reset.

Verification (defaults, N_LINES=4, LINE_WORDS=4)
REQ-035 Cold miss: req 0x40 -> mem_addr 0x40,0x44,0x48,0x4C; data A0..A3 -> rvalid_o with rdata A0 one cycle after RESPOND entry.
REQ-036 Hit: then req 0x48 -> rvalid_o next cycle, rdata A2, mem_req_o stays 0.
REQ-037 Conflict: req 0x80 (same index, tag 2) -> refill B0..B3 at 0x80..0x8C; then req 0x40 misses again.
REQ-038 Flush: flush_i with req_i in IDLE -> ready_o 0, request dropped; next req 0x48 misses.
REQ-039 Stall/reset: mem_valid_i with 3-cycle gaps completes correctly; resetn_i low after 2 words -> mem_req_o 0 immediately; req 0x40 after release misses.
